vga_char_fetch: RTL
===================

Name: vga_char_fetch

Overview:
Character/font fetch sequencer that feeds the 10-bit pixel shift register of the VGA text controller.
- Per character cell, reads the character code from text RAM, then the font row from font ROM.
- Presents the font byte together with a one-cycle load strobe every CHAR_W pixel clocks.
- Sits between the VGA timing generator (line/frame pulses) and the shift register. It is the producer side of the shift register's i_data/i_ld_h interface.

Parameters:
COLS, 80, characters per text row
ROWS, 30, text rows per frame
CHAR_W, 10, pixel clocks per character cell (8 font pixels + 2 gap)
FONT_H, 16, scan lines per character row (font row index is 4 bits)
TXT_AW, 12, text RAM address width (COLS*ROWS <= 2^TXT_AW)

Ports:
i_clk  in  1  pixel clock
i_rst_h  in  1  synchronous active-high reset
i_cs_h  in  1  block enable; low = no new line fetch starts, no strobes
i_frame_start  in  1  one-cycle pulse, start of frame
i_line_start  in  1  one-cycle pulse, 5 cycles before first active pixel of a line
o_txt_addr  out  TXT_AW  text RAM address (registered)
i_txt_data  in  8  text RAM read data, valid 1 cycle after address
o_font_addr  out  12  font ROM address {char[7:0], font_row[3:0]} (registered)
i_font_data  in  8  font ROM read data, valid 1 cycle after address
o_data  out  8  font byte to shift register
o_ld_h  out  1  load strobe to shift register, one cycle per character
o_busy  out  1  high while a line fetch is in progress (RUN or DRAIN)

Behaviour:
- One clock; reset is synchronous, active-high, on i_rst_h sampled at posedge i_clk.
- Reset values:
  - o_txt_addr=0, o_font_addr=0, o_data=0, o_ld_h=0, o_busy=0.
  - Internal font_row=0, text_row=0, row_base=0, col=0, pix=0, state=IDLE.
- FSM states:
  - IDLE: waits for a line start.
  - RUN: issues COLS text addresses.
  - DRAIN: 4 cycles to flush the pipeline.
- IDLE->RUN: on i_line_start=1 with i_cs_h=1 and text_row<ROWS. Otherwise the line start is ignored and the state stays IDLE with no strobes.
- Pipeline, with T = i_line_start cycle and c = 0..COLS-1:
  - cycle T+CHAR_W*c: o_txt_addr = row_base + c.
  - cycle T+CHAR_W*c+2: o_font_addr = {txt byte, font_row}.
  - cycle T+CHAR_W*c+4: o_ld_h=1, o_data = font byte.
  - Load-strobe latency from i_line_start is 4 cycles; pixels appear from the shift register at T+5.
- pix counts 0..CHAR_W-1 and wraps. col increments on pix wrap. RUN->DRAIN after the address for col=COLS-1 is issued (pix wraps at col=COLS-1).
- DRAIN->IDLE after the last o_ld_h cycle.
- On the DRAIN->IDLE transition:
  - font_row increments.
  - On font_row wrap FONT_H-1->0: text_row increments and row_base += COLS.
- o_ld_h is exactly one cycle wide. o_data holds its value between strobes. o_txt_addr and o_font_addr hold their last value in IDLE.
- i_frame_start clears font_row, text_row, row_base, aborts any fetch, and returns to IDLE. Any strobe still in flight is suppressed.
- i_frame_start and i_line_start in the same cycle: the frame reset is applied, then the fetch starts for text row 0, font row 0.
- i_line_start while busy: ignored; no restart.
- i_cs_h low mid-line: the current line completes; cs gates only new line starts.
- text_row==ROWS: all line starts are ignored until i_frame_start.
- i_rst_h mid-line: all registers take reset values the next cycle. No further strobes are issued until a new i_line_start.

Test Plan:
1. Text RAM holds char=c at address c; frame_start+line_start at cycle 0 -> o_txt_addr=0,1,…,79 at cycles 0,10,…,790; o_font_addr=0x000,0x010,…,0x4F0 at cycles 2,12,…; o_ld_h at cycles 4,14,…,794 (exactly 80 pulses); o_data = ROM[{c,0}]; o_busy low from cycle 795.
2. 17 line starts spaced 800 cycles apart after frame_start -> lines 0–15 read text addr 0–79 with font_row 0..15; line 16 reads addr 80–159 with font_row 0.
3. 481 line starts after frame_start -> line 480 produces no o_txt_addr change and no o_ld_h; a new frame_start then re-fetches addr 0.
4. line_start pulsed again at cycle 300 of a running line -> ignored; strobe spacing stays 10, total 80 strobes.
5. i_rst_h for 1 cycle at cycle 405 -> next cycle all outputs 0, o_ld_h stays 0 to end of line; the next line_start fetches row 0, font_row 0.
6. i_cs_h=0 at line_start -> no strobes, counters unchanged; i_cs_h dropped at cycle 100 of an active line -> line still completes with 80 strobes.

Source files
------------

// File: rtl/vga_char_fetch.sv
// Character/font fetch sequencer for the VGA text controller.
// Each character cell reads the character code from text RAM and then
// the matching font row from font ROM. It hands the font byte to the
// pixel shift register with a one-cycle load strobe every CHAR_W clocks.
module vga_char_fetch #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int CHAR_W = 10,
    parameter int FONT_H = 16,
    parameter int TXT_AW = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_h,
    input  logic              i_cs_h,
    input  logic              i_frame_start,
    input  logic              i_line_start,
    output logic [TXT_AW-1:0] o_txt_addr,
    input  logic [7:0]        i_txt_data,
    output logic [11:0]       o_font_addr,
    input  logic [7:0]        i_font_data,
    output logic [7:0]        o_data,
    output logic              o_ld_h,
    output logic              o_busy
);

    localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PIX_W     = $clog2(CHAR_W);
    localparam int ROW_W     = $clog2(ROWS + 1);
    localparam int FR_W      = 4;
    localparam int DRAIN_LEN = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [COL_W-1:0]    col;
    logic [PIX_W-1:0]    pix;
    logic [FR_W-1:0]     font_row;
    logic [ROW_W-1:0]    text_row;
    logic [TXT_AW-1:0]   row_base;

    logic                start, issue, line_done;
    logic [ROW_W-1:0]    row_eff;
    logic [TXT_AW-1:0]   base_eff;
    logic                vld_p0, vld_p1, vld_p2, vld_p3;

    // Start/issue/done decisions and next-state selection; a frame start
    // acts as if the row counters were already cleared this cycle.
    always_comb begin
        row_eff   = i_frame_start ? '0 : text_row;
        base_eff  = i_frame_start ? '0 : row_base;
        start     = i_line_start && i_cs_h &&
                    (i_frame_start || (state == IDLE)) &&
                    (row_eff < ROW_W'(ROWS));
        issue     = (state == RUN) && !i_frame_start &&
                    (pix == PIX_W'(CHAR_W - 1));
        line_done = (state == DRAIN) && !i_frame_start &&
                    (pix == PIX_W'(DRAIN_LEN));
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if ((col == COL_W'(COLS - 1)) && (pix == '0)) state_nxt = DRAIN;
            DRAIN:   if (pix == PIX_W'(DRAIN_LEN)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_frame_start) state_nxt = IDLE;
        if (start)         state_nxt = RUN;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst_h) state <= IDLE;
        else         state <= state_nxt;
    end

    // Cell/pixel counters, text address generation and per-line row bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst_h) begin
            col        <= '0;
            pix        <= '0;
            font_row   <= '0;
            text_row   <= '0;
            row_base   <= '0;
            o_txt_addr <= '0;
        end else begin
            if (i_frame_start) begin
                font_row <= '0;
                text_row <= '0;
                row_base <= '0;
            end else if (line_done) begin
                if (font_row == FR_W'(FONT_H - 1)) begin
                    font_row <= '0;
                    text_row <= text_row + ROW_W'(1);
                    row_base <= row_base + TXT_AW'(COLS);
                end else begin
                    font_row <= font_row + FR_W'(1);
                end
            end
            if (start) begin
                col        <= '0;
                pix        <= '0;
                o_txt_addr <= base_eff;
            end else if (!i_frame_start && (state != IDLE)) begin
                if (issue) begin
                    pix        <= '0;
                    col        <= col + COL_W'(1);
                    o_txt_addr <= o_txt_addr + TXT_AW'(1);
                end else begin
                    pix <= pix + PIX_W'(1);
                end
            end
        end
    end

    // Fetch pipeline: p0 address out, p1 char valid -> font address,
    // p3 font byte valid -> load strobe. A frame start kills anything in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst_h) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            vld_p3      <= 1'b0;
            o_ld_h      <= 1'b0;
            o_data      <= '0;
            o_font_addr <= '0;
        end else begin
            vld_p0 <= start || issue;
            vld_p1 <= vld_p0 && !i_frame_start;
            vld_p2 <= vld_p1 && !i_frame_start;
            vld_p3 <= vld_p2 && !i_frame_start;
            o_ld_h <= vld_p3 && !i_frame_start;
            if (vld_p1 && !i_frame_start) o_font_addr <= {i_txt_data, font_row};
            if (vld_p3 && !i_frame_start) o_data <= i_font_data;
        end
    end

    assign o_busy = (state != IDLE);

endmodule
